// File: rtl/cache_controller_pkg.sv
// Shared constants, state encoding and address helper
// for the MEM-stage cache controller.
package cache_controller_pkg;

    localparam int ADDR_BASE      = 1024;
    localparam int ADDR_LEN       = 32;
    localparam int DATA_LEN       = 32;
    localparam int BLOCK_LEN      = 64;
    localparam int CACHE_ADDR_LEN = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        FILL    = 2'd2,
        WR      = 2'd3
    } state_e;

    // Word address relative to the base; wraps silently
    function automatic logic [CACHE_ADDR_LEN-1:0] to_cache_addr(
        input logic [ADDR_LEN-1:0] a
    );
        logic [ADDR_LEN-1:0] off;
        off = a - ADDR_LEN'(ADDR_BASE);
        return off[CACHE_ADDR_LEN+1:2];
    endfunction

endpackage

// File: rtl/cache_controller.sv
// Write-through read-allocate controller between the
// MEM stage, the 2-way cache and the SRAM controller.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic                      wr_en,
    input  logic [ADDR_LEN-1:0]       address,
    input  logic [DATA_LEN-1:0]       wdata,
    output logic [DATA_LEN-1:0]       rdata,
    output logic                      ready,
    output logic [CACHE_ADDR_LEN-1:0] cache_addr,
    output logic                      cache_rd_en,
    output logic                      cache_wr_en,
    output logic [BLOCK_LEN-1:0]      cache_wdata,
    output logic                      cache_inval,
    input  logic [DATA_LEN-1:0]       cache_rdata,
    input  logic                      cache_hit,
    output logic                      sram_rd_en,
    output logic                      sram_wr_en,
    output logic [ADDR_LEN-1:0]       sram_address,
    output logic [DATA_LEN-1:0]       sram_wdata,
    input  logic [BLOCK_LEN-1:0]      sram_rdata,
    input  logic                      sram_ready
);

    state_e               state_q, state_d;
    logic [BLOCK_LEN-1:0] blk_q, blk_d;

    assign cache_addr   = to_cache_addr(address);
    assign cache_wdata  = blk_q;
    assign sram_address = address;
    assign sram_wdata   = wdata;

    // Next state, captured block and handshake outputs;
    // everything is held quiet while reset is asserted
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        ready       = 1'b1;
        rdata       = '0;
        cache_rd_en = 1'b0;
        cache_wr_en = 1'b0;
        cache_inval = 1'b0;
        sram_rd_en  = 1'b0;
        sram_wr_en  = 1'b0;
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        ready       = 1'b0;
                        cache_inval = 1'b1;
                        state_d     = WR;
                    end else if (rd_en) begin
                        if (cache_hit) begin
                            rdata       = cache_rdata;
                            cache_rd_en = 1'b1;
                        end else begin
                            ready   = 1'b0;
                            state_d = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    ready      = 1'b0;
                    sram_rd_en = 1'b1;
                    if (sram_ready) begin
                        blk_d   = sram_rdata;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    cache_wr_en = 1'b1;
                    rdata       = cache_addr[0] ?
                                  blk_q[BLOCK_LEN-1:DATA_LEN] :
                                  blk_q[DATA_LEN-1:0];
                    state_d     = IDLE;
                end
                WR: begin
                    sram_wr_en = 1'b1;
                    ready      = sram_ready;
                    if (sram_ready) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // State and block register; reset aborts any miss or write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller with a small
// direct-mapped cache model and a latency-programmable SRAM.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic [16:0] cache_addr;
    logic        cache_rd_en, cache_wr_en, cache_inval;
    logic [63:0] cache_wdata;
    logic [31:0] cache_rdata;
    logic        cache_hit;
    logic        sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int errs   = 0;
    int checks = 0;
    int lat    = 4;
    int done_cnt = 0;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          stalls;
        int          srd;
        int          swr;
        int          fill;
        int          inval;
        int          crd;
    } exp_t;

    exp_t sb[$];

    cache_controller dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .wdata(wdata),
        .rdata(rdata), .ready(ready),
        .cache_addr(cache_addr),
        .cache_rd_en(cache_rd_en),
        .cache_wr_en(cache_wr_en),
        .cache_wdata(cache_wdata),
        .cache_inval(cache_inval),
        .cache_rdata(cache_rdata),
        .cache_hit(cache_hit),
        .sram_rd_en(sram_rd_en),
        .sram_wr_en(sram_wr_en),
        .sram_address(sram_address),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    // SRAM: fixed contents, ready pulse in the lat-th request cycle
    int scnt;
    assign sram_rdata = (sram_address[31:3] == 29'h80) ?
                        64'hAAAA_BBBB_1111_2222 :
                        {~sram_address, sram_address};
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_ready <= 1'b0;
            scnt       <= 0;
        end else if (sram_ready) begin
            sram_ready <= 1'b0;
            scnt       <= 0;
        end else if (sram_rd_en || sram_wr_en) begin
            if (scnt == lat - 2) sram_ready <= 1'b1;
            else scnt <= scnt + 1;
        end
    end

    // Cache sibling: direct-mapped, index [6:1], tag [16:7]
    logic        cv [64];
    logic [9:0]  ctag [64];
    logic [63:0] cdat [64];
    logic [5:0]  cidx;
    assign cidx = cache_addr[6:1];
    assign cache_hit = cv[cidx] && (ctag[cidx] == cache_addr[16:7]);
    assign cache_rdata = cache_addr[0] ? cdat[cidx][63:32] :
                                         cdat[cidx][31:0];
    initial for (int i = 0; i < 64; i++) cv[i] = 1'b0;
    always @(posedge clk) begin
        if (cache_wr_en) begin
            cv[cidx]   <= 1'b1;
            ctag[cidx] <= cache_addr[16:7];
            cdat[cidx] <= cache_wdata;
        end
        if (cache_inval && cache_hit) cv[cidx] <= 1'b0;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: accumulate strobes per request, compare on ready
    int m_st, m_srd, m_swr, m_fill, m_inv, m_crd;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            {m_st, m_srd, m_swr, m_fill, m_inv, m_crd} = '0;
        end else if (rd_en || wr_en) begin
            if (!ready) m_st++;
            m_srd  += int'(sram_rd_en);
            m_swr  += int'(sram_wr_en);
            m_fill += int'(cache_wr_en);
            m_inv  += int'(cache_inval);
            m_crd  += int'(cache_rd_en);
            if (ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("stalls", 64'(m_st), 64'(e.stalls));
                    chk("sram_rd", 64'(m_srd), 64'(e.srd));
                    chk("sram_wr", 64'(m_swr), 64'(e.swr));
                    chk("fill", 64'(m_fill), 64'(e.fill));
                    chk("inval", 64'(m_inv), 64'(e.inval));
                    chk("crd", 64'(m_crd), 64'(e.crd));
                    chk("sram_addr", 64'(sram_address), 64'(e.addr));
                    if (e.is_wr)
                        chk("sram_wdata", 64'(sram_wdata), 64'(e.data));
                    else
                        chk("rdata", 64'(rdata), 64'(e.data));
                end
                {m_st, m_srd, m_swr, m_fill, m_inv, m_crd} = '0;
                done_cnt++;
            end
        end else begin
            chk("idle_rdata", 64'(rdata), 64'd0);
            chk("idle_en", 64'({cache_rd_en, cache_wr_en, cache_inval,
                                sram_rd_en, sram_wr_en}), 64'd0);
        end
    end

    task automatic issue(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int l, input logic [31:0] d,
                         input int st, input int srd, input int swr,
                         input int fill, input int inv, input int crd);
        exp_t e;
        int start;
        e = '{w, a, d, st, srd, swr, fill, inv, crd};
        sb.push_back(e);
        lat = l;
        start = done_cnt;
        rd_en = r; wr_en = w; address = a; wdata = wd;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (done_cnt != start) break;
        end
        if (done_cnt == start) begin
            checks++; errs++;
            $display("FAIL timeout: addr %h got no ready want ready", a);
        end
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int fills;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        address = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_en", 64'({cache_rd_en, cache_wr_en, cache_inval,
                           sram_rd_en, sram_wr_en}), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // T1: reset in the middle of a read miss
        lat = 4; rd_en = 1'b1; address = 32'h800;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_srd_before", 64'(sram_rd_en), 64'd1);
        #2;
        rst = 1'b0; rd_en = 1'b0;
        #1;
        chk("t1_srd_abort", 64'(sram_rd_en), 64'd0);
        chk("t1_fill_abort", 64'(cache_wr_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        fills = 0;
        repeat (6) begin
            @(negedge clk);
            fills += int'(cache_wr_en);
        end
        chk("t1_no_fill", 64'(fills), 64'd0);
        @(posedge clk); #1;

        // r w addr wdata lat data stalls srd swr fill inv crd
        issue(1, 0, 32'h800, 0, 4, 32'h800, 5, 4, 0, 1, 0, 0);
        issue(1, 0, 32'h400, 0, 4, 32'h1111_2222, 5, 4, 0, 1, 0, 0);
        issue(1, 0, 32'h404, 0, 4, 32'hAAAA_BBBB, 0, 0, 0, 0, 0, 1);
        issue(1, 0, 32'h400, 0, 4, 32'h1111_2222, 0, 0, 0, 0, 0, 1);
        issue(0, 1, 32'h400, 5, 3, 32'h5, 3, 0, 3, 0, 1, 0);
        issue(1, 0, 32'h400, 0, 4, 32'h1111_2222, 5, 4, 0, 1, 0, 0);
        issue(1, 1, 32'h408, 32'h77, 2, 32'h77, 2, 0, 2, 0, 1, 0);
        issue(1, 0, 32'h8_0404, 0, 4, 32'hAAAA_BBBB, 0, 0, 0, 0, 0, 1);
        issue(1, 0, 32'h3FC, 0, 2, 32'hFFFF_FC03, 3, 2, 0, 1, 0, 0);
        issue(1, 0, 32'h3FC, 0, 2, 32'hFFFF_FC03, 0, 0, 0, 0, 0, 1);
        issue(1, 0, 32'h500, 0, 2, 32'h500, 3, 2, 0, 1, 0, 0);

        address = 32'h3FC;
        #1;
        chk("below_base_addr", 64'(cache_addr), 64'h1_FFFF);
        address = 32'h8_0400;
        #1;
        chk("wrap_addr", 64'(cache_addr), 64'h0);

        repeat (3) @(posedge clk);
        chk("sb_left", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
